// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, transaction tag and address map.
package mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {TAG_I, TAG_D} tag_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_LIM_DEF = 4;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
endpackage

// File: rtl/lat_counter.sv
// Down-counter timing the memory latency window; done flags the final WAIT cycle.
module lat_counter #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= CW'(MAX);
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CW'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one fixed-latency single-port memory.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIM + 1);

  state_t        state, state_nxt;
  tag_t          tag;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          we_q;
  logic          flushed;
  logic [SW-1:0] streak;
  logic          i_vld_q, d_vld_q;
  logic          cnt_load, cnt_dec, cnt_done;
  logic          issue, finish;

  lat_counter #(.MAX(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .done (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          // Data wins unless fetch has been waiting through a full streak.
          if (d_req && !(i_req && streak == SW'(STARVE_LIM))) d_ready = 1'b1;
          else if (i_req)                                     i_ready = 1'b1;
        end
        if (i_ready || d_ready) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_load  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign finish = (state == ST_WAIT) && cnt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tag     <= TAG_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      flushed <= 1'b0;
      streak  <= '0;
      i_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_nxt;
      i_vld_q <= 1'b0;
      d_vld_q <= 1'b0;

      if (i_ready || d_ready) begin
        tag     <= d_ready ? TAG_D : TAG_I;
        addr_q  <= d_ready ? d_addr[31:2] : i_addr[31:2];
        we_q    <= d_ready && d_we;
        wdata_q <= d_ready ? d_wdata : '0;
        wstrb_q <= (d_ready && d_we) ? d_wstrb : 4'b0000;
        flushed <= 1'b0;
      end else if (state != ST_IDLE && tag == TAG_I && i_flush) begin
        flushed <= 1'b1;
      end

      if (state == ST_IDLE) begin
        if (i_ready || !i_req)                          streak <= '0;
        else if (d_ready && streak != SW'(STARVE_LIM))  streak <= streak + 1'b1;
      end

      if (finish) begin
        if (tag == TAG_D) begin
          d_vld_q <= 1'b1;
          if (!we_q) d_rdata <= mem_rdata;
        end else if (!(flushed || i_flush)) begin
          i_vld_q <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

  // A flush landing on the pulse cycle itself still kills the fetch.
  assign i_valid = i_vld_q && !i_flush;
  assign d_valid = d_vld_q;

  assign issue     = (state == ST_ISSUE);
  assign mem_en    = issue;
  assign mem_we    = issue && we_q;
  assign mem_addr  = issue ? {addr_q, 2'b00} : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign mem_wstrb = issue ? wstrb_q : 4'b0000;
endmodule
